// File: rtl/run_ctrl_if.sv
// Host/core/memory signal bundle for the run_ctrl sequencer.
// slave = the sequencer itself, master = the surrounding host, core and memory.
interface run_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          core_start;
  logic          core_halt;
  logic          mem_own;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          done;
  logic          timed_out;
  logic [15:0]   run_cycles;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, core_halt, mem_rdata,
    output in_ready, out_valid, out_data, out_last, core_start,
           mem_own, mem_addr, mem_wdata, mem_we, done, timed_out, run_cycles
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, core_halt, mem_rdata,
    input  in_ready, out_valid, out_data, out_last, core_start,
           mem_own, mem_addr, mem_wdata, mem_we, done, timed_out, run_cycles
  );
endinterface

// File: rtl/run_ctrl.sv
// Host-side sequencer: loads operands into data memory, runs the core until halt
// or timeout, then streams the result window back out over a valid/ready port.
module run_ctrl #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int LOAD_BASE    = 0,
  parameter int RES_BASE     = 64,
  parameter int RES_LEN      = 4,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        reset_n,
  run_ctrl_if.slave   bus
);
  localparam int IW = (RES_LEN > 1) ? $clog2(RES_LEN) : 1;
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE} state_e;

  state_e        state_q;
  logic          core_start_q;
  logic          mem_own_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic          done_q;
  logic          timed_out_q;
  logic [15:0]   run_cycles_q;
  logic [AW-1:0] ptr_q;
  logic [IW-1:0] idx_q;
  logic [SW-1:0] start_cnt_q;

  logic          load_phase;
  logic          accept;
  logic          timeout_hit;
  logic [AW-1:0] load_ptr;

  assign load_phase  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_DONE);
  assign accept      = bus.in_valid && bus.in_ready;
  assign timeout_hit = (run_cycles_q + 16'd1) == 16'(TIMEOUT);
  // A load started from IDLE or DONE always restarts at the base address.
  assign load_ptr    = (state_q == S_LOAD) ? ptr_q : '0;

  assign bus.in_ready   = load_phase && reset_n;
  assign bus.mem_we     = accept;
  assign bus.mem_wdata  = bus.in_data;
  assign bus.mem_addr   = (state_q == S_DUMP) ? AW'(RES_BASE) + AW'(idx_q)
                                              : AW'(LOAD_BASE) + load_ptr;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_data   = out_valid_q ? bus.mem_rdata : DW'(0);
  assign bus.core_start = core_start_q;
  assign bus.mem_own    = mem_own_q;
  assign bus.done       = done_q;
  assign bus.timed_out  = timed_out_q;
  assign bus.run_cycles = run_cycles_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      core_start_q <= 1'b1;
      mem_own_q    <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
      run_cycles_q <= '0;
      ptr_q        <= '0;
      idx_q        <= '0;
      start_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_LOAD, S_DONE: begin
          if (accept) begin
            ptr_q        <= load_ptr + 1'b1;
            core_start_q <= 1'b1;
            if (state_q != S_LOAD) begin
              done_q      <= 1'b0;
              timed_out_q <= 1'b0;
            end
            if (bus.in_last) begin
              state_q     <= S_START;
              mem_own_q   <= 1'b0;
              start_cnt_q <= '0;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        S_START: begin
          if (start_cnt_q == SW'(START_CYCLES - 1)) begin
            state_q      <= S_RUN;
            core_start_q <= 1'b0;
            run_cycles_q <= '0;
          end else begin
            start_cnt_q <= start_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          // The halt cycle itself is not counted; halt wins over a coincident timeout.
          if (!bus.core_halt) begin
            run_cycles_q <= run_cycles_q + 16'd1;
            if (timeout_hit) timed_out_q <= 1'b1;
          end
          if (bus.core_halt || timeout_hit) begin
            state_q     <= S_DUMP;
            mem_own_q   <= 1'b1;
            out_valid_q <= 1'b1;
            out_last_q  <= (RES_LEN == 1);
            idx_q       <= '0;
          end
        end
        S_DUMP: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx_q      <= idx_q + 1'b1;
              out_last_q <= (idx_q + 1'b1) == IW'(RES_LEN - 1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Host-side sequencer sitting directly upstream of the ACDC core and its data memory.
- Streams a program's operand bytes into data memory while holding the core in init.
- Releases the core and counts cycles until halt (with timeout).
- Streams the result bytes back out of data memory through a valid/ready port.

Parameters:
- AW, 8, data memory address width.
- DW, 8, data memory word width.
- LOAD_BASE, 0, first data memory address written by the load stream.
- RES_BASE, 64, first data memory address read back in the dump.
- RES_LEN, 4, number of result bytes dumped (≥1).
- START_CYCLES, 2, cycles core_start stays high after the last load byte (≥1).
- TIMEOUT, 16'hFFFF, run-cycle limit before forced abort.

Ports:
- CLK, in, 1, clock; posedge only.
- reset_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, load byte valid.
- in_data, in, DW, load byte.
- in_last, in, 1, marks final load byte.
- in_ready, out, 1, load byte accepted when in_valid&in_ready.
- out_valid, out, 1, result byte valid.
- out_data, out, DW, result byte.
- out_last, out, 1, marks final result byte.
- out_ready, in, 1, host accepts result byte.
- core_start, out, 1, drives the core's start (init, active high).
- core_halt, in, 1, core's halt flag.
- mem_own, out, 1, 1 = this block owns the data memory port; 0 = core owns it.
- mem_addr, out, AW, data memory address.
- mem_wdata, out, DW, data memory write data.
- mem_we, out, 1, data memory write enable.
- mem_rdata, in, DW, data memory read data (combinational read).
- done, out, 1, run complete, results dumped.
- timed_out, out, 1, last run hit TIMEOUT.
- run_cycles, out, 16, cycles counted in the last run.

Behaviour:
- Reset (asynchronous, reset_n low) puts every output in its reset state immediately, from any state including mid-load, mid-run or mid-dump:
  - state = IDLE.
  - core_start = 1, mem_own = 1.
  - mem_we = 0, out_valid = 0, out_last = 0.
  - done = 0, timed_out = 0, run_cycles = 0, pointers = 0.
  - in_ready is forced to 0 while reset_n is low.
- States: IDLE, LOAD, START, RUN, DUMP, DONE. core_start = 1 in IDLE/LOAD/START and 0 elsewhere; mem_own = 0 only in START/RUN.
- IDLE/LOAD/DONE:
  - in_ready = 1.
  - Accepted byte: mem_we = 1 in the same cycle, mem_addr = LOAD_BASE+ptr (mod 2^AW), mem_wdata = in_data.
  - ptr increments by 1 per accepted byte; the address wraps to 0 past 2^AW-1.
  - First accepted byte in IDLE/DONE: ptr restarts at 0, done and timed_out clear, state -> LOAD.
  - Accepted byte with in_last=1 (including the first byte) -> START.
  - No zero-length loads.
- START:
  - in_ready = 0.
  - Holds for START_CYCLES cycles, then -> RUN with core_start low from the first RUN cycle.
- RUN:
  - run_cycles clears on entry and increments each cycle core_halt=0.
  - core_halt=1 -> DUMP; run_cycles is frozen (halt cycle not counted).
  - If run_cycles reaches TIMEOUT with halt still low: timed_out = 1, -> DUMP.
  - in_valid is ignored in RUN.
- DUMP:
  - mem_addr = RES_BASE+idx (mod 2^AW); out_data = mem_rdata; out_valid = 1.
  - out_last = (idx == RES_LEN-1).
  - out_valid/out_data/out_last stay stable until out_ready.
  - Each handshake increments idx; the handshake on the last byte -> DONE.
  - mem_we = 0 throughout.
- DONE:
  - done = 1; run_cycles and timed_out are held.
  - Core stays halted, core_start = 0.
- Latency:
  - Load byte to memory: 0 cycles (same-cycle write).
  - Last load byte to core release: START_CYCLES+1 cycles.
  - Halt seen to first out_valid: 1 cycle.
- Simultaneous in_last and wrap: write at the wrapped address, then -> START.

Test Plan:
- Load 3 bytes 0x11,0x22,0x33 (last on 3rd), LOAD_BASE=0 -> writes addr 0,1,2 on accept cycles; core_start falls exactly START_CYCLES+1 cycles after 3rd accept.
- Core model raises halt after 10 low cycles, memory 64..67 = 0xA0..0xA3 -> run_cycles=10, out_data A0,A1,A2,A3 with out_last on A3, then done=1, timed_out=0.
- Dump with out_ready toggling 1,0,0,1,… -> out_data/out_last stable while stalled; no byte skipped or duplicated.
- TIMEOUT=20, halt never rises -> timed_out=1, run_cycles=20, dump still emits RES_LEN bytes, done=1.
- LOAD_BASE=254, 4 bytes -> writes addr 254,255,0,1.
- reset_n low mid-RUN and mid-DUMP -> immediate IDLE values (core_start=1, out_valid=0, done=0); new load after release behaves as a fresh run; second run after DONE clears done on first accepted byte.
